// File: rtl/fifo_stream_reader_pkg.sv
// fifo_reader_pkg: shared constants and types for the FIFO stream reader.
//   SKID_DEPTH : number of entries in the output buffer.
//   occ_t      : buffer occupancy (0..SKID_DEPTH).
package fifo_reader_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO-side and stream-side handshake bundle.
//   empty, fifoData, read       : FIFO pop interface (data arrives one cycle after read)
//   outValid, outReady, outData : downstream valid/ready stream
// master = the reader block, slave = the FIFO/downstream side.
interface fifo_stream_reader_if #(
  parameter int unsigned width = 8
) ();

  logic             empty;
  logic [width-1:0] fifoData;
  logic             read;
  logic             outValid;
  logic             outReady;
  logic [width-1:0] outData;

  modport master (
    input  empty, fifoData, outReady,
    output read, outValid, outData
  );

  modport slave (
    output empty, fifoData, outReady,
    input  read, outValid, outData
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// reader_skid_buf: 2-entry in-order buffer between the FIFO read port and the
// output stream.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write din at the tail
//   pop        : drop the head word (caller guarantees occupancy != 0)
//   dout       : head (oldest) word
//   occupancy  : number of stored words
module reader_skid_buf
  import fifo_reader_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output occ_t             occupancy
);

  logic [width-1:0] mem [SKID_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= '0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pulls words from a first-word-latency-1 FIFO and presents
// them as a valid/ready stream through a 2-entry buffer.
//   clk, reset : clock, synchronous active-high reset
//   enable     : permits new FIFO reads (buffered/in-flight words still drain)
//   bus        : FIFO pop port and output stream (master modport)
//   wordCount  : words accepted downstream since reset (wraps)
//   busy       : a read is in flight or the buffer holds data
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned width    = 8,
  parameter int unsigned cntWidth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  fifo_stream_reader_if.master   bus,
  output logic [cntWidth-1:0]    wordCount,
  output logic                   busy
);

  logic       in_flight;
  logic       pop;
  logic       has_data;
  logic [2:0] credit;
  occ_t       occupancy;

  assign has_data     = (occupancy != '0);
  assign bus.outValid = has_data && !reset;
  assign pop          = bus.outValid && bus.outReady;

  // Words committed to the buffer by the next edge; a new read only lands one
  // cycle later, so it must fit on top of this figure.
  assign credit   = 3'(occupancy) + 3'(in_flight) - 3'(pop);
  assign bus.read = !reset && enable && !bus.empty && (credit < 3'(SKID_DEPTH));

  assign busy = !reset && (in_flight || has_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight <= 1'b0;
      wordCount <= '0;
    end else begin
      in_flight <= bus.read;
      if (pop) begin
        wordCount <= wordCount + cntWidth'(1);
      end
    end
  end

  reader_skid_buf #(
    .width(width)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (in_flight),
    .pop      (pop),
    .din      (bus.fifoData),
    .dout     (bus.outData),
    .occupancy(occupancy)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: expected words are queued as the
// FIFO model is loaded; a monitor pops and compares on every accepted word.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] wordCount;
  logic        busy;
  logic [3:0]  wordCount2;
  logic        busy2;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_stream_reader_if #(.width(8)) bus  ();
  fifo_stream_reader_if #(.width(8)) bus2 ();

  fifo_stream_reader #(.width(8), .cntWidth(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus),
    .wordCount(wordCount),
    .busy     (busy)
  );

  fifo_stream_reader #(.width(8), .cntWidth(4)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus2),
    .wordCount(wordCount2),
    .busy     (busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: write side filled by the main process, read side advanced by
  // NBA so the DUT sees a race-free empty flag and one-cycle read latency.
  logic [7:0] fifo_mem [64];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         wr2    = 0;
  int         rd2    = 0;

  assign bus.empty     = (rd_cnt == wr_cnt);
  assign bus2.empty    = (rd2 == wr2);
  assign bus2.outReady = 1'b1;
  assign bus2.fifoData = 8'(rd2);

  always @(posedge clk) begin
    if (bus.read) begin
      check("read_while_empty", 32'(rd_cnt != wr_cnt), 32'd1);
      bus.fifoData <= fifo_mem[rd_cnt[5:0]];
      rd_cnt       <= rd_cnt + 1;
    end
    if (bus2.read) begin
      rd2 <= rd2 + 1;
    end
  end

  // Scoreboard monitor.
  logic [7:0] exp_q [$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(bus.outValid), 32'd1);
        check("hold_data", 32'(bus.outData), 32'(prev_data));
      end
      if (bus.outValid && bus.outReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(bus.outData), 32'hFFFF_FFFF);
        end else begin
          check("stream_data", 32'(bus.outData), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = bus.outValid && !bus.outReady;
      prev_data = bus.outData;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[(wr_cnt + i) % 64] = first + 8'(i);
    end
    wr_cnt = wr_cnt + n;
  endtask

  task automatic expect_words(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 8'(i));
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_q.size() != 0 || busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gaps, reads, bad;
    bus.outReady = 1'b0;

    // Reset state
    cyc();
    cyc();
    @(negedge clk);
    check("rst_read", 32'(bus.read), 32'd0);
    check("rst_valid", 32'(bus.outValid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(bus.outData), 32'd0);
    check("rst_count", 32'(wordCount), 32'd0);
    check("rst_count2", 32'(wordCount2), 32'd0);
    cyc();
    reset = 1'b0;
    enable = 1'b1;
    bus.outReady = 1'b1;

    // Empty guard
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.read || bus.outValid || busy) bad++;
    end
    check("empty_guard", 32'(bad), 32'd0);

    // Stream 00..0F
    cyc();
    load(8'h00, 16);
    expect_words(8'h00, 16);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.outValid) break;
    end
    check("latency", 32'(lat), 32'd3);
    gaps = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (!bus.outValid) gaps++;
    end
    check("stream_gaps", 32'(gaps), 32'd0);
    @(negedge clk);
    check("stream_end", 32'(bus.outValid), 32'd0);
    drain("stream_drain");
    check("stream_count", 32'(wordCount), 32'd16);

    // Backpressure with 5 words
    cyc();
    bus.outReady = 1'b0;
    load(8'h00, 5);
    expect_words(8'h00, 5);
    reads = 0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.read) reads++;
      if (bus.outValid && bus.outData != 8'h00) bad++;
    end
    check("bp_reads", 32'(reads), 32'd2);
    check("bp_head", 32'(bad), 32'd0);
    check("bp_valid", 32'(bus.outValid), 32'd1);
    cyc();
    bus.outReady = 1'b1;
    drain("bp_drain");
    check("bp_count", 32'(wordCount), 32'd21);

    // Enable drop the cycle after a read
    cyc();
    load(8'hA0, 3);
    expect_words(8'hA0, 1);
    cyc();
    enable = 1'b0;
    reads = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.read) reads++;
    end
    check("en_no_reads", 32'(reads), 32'd0);
    drain("en_drain");
    check("en_count", 32'(wordCount), 32'd22);
    cyc();
    enable = 1'b1;
    expect_words(8'hA1, 2);
    drain("en_resume");
    check("en_count2", 32'(wordCount), 32'd24);

    // Reset mid-stream with a word buffered and one in flight
    cyc();
    bus.outReady = 1'b0;
    load(8'hB0, 4);
    cyc();
    cyc();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_valid", 32'(bus.outValid), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out", 32'({bus.read, bus.outValid, busy}), 32'd0);
    cyc();
    reset = 1'b0;
    bus.outReady = 1'b1;
    expect_words(8'hB2, 2);
    @(negedge clk);
    check("mid_first_read", 32'(bus.read), 32'd1);
    check("mid_valid_clr", 32'(bus.outValid), 32'd0);
    check("mid_count_clr", 32'(wordCount), 32'd0);
    drain("mid_drain");
    check("mid_count", 32'(wordCount), 32'd2);

    // Counter wrap on the 4-bit instance
    cyc();
    wr2 = 17;
    lat = 0;
    while ((rd2 != 17 || busy2) && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    check("wrap_done", 32'(rd2 == 17 && !busy2), 32'd1);
    check("wrap_count", 32'(wordCount2), 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
